// File: rtl/uart_pkg.sv
// UART shared package: rx FSM states, default line constants
// and the oversample divider helper used by both rx and tx.
package uart_pkg;

  localparam int CLK_FREQ_HZ   = 100_000_000;
  localparam int BAUD_9600     = 9600;
  localparam int OVERSAMPLE_16 = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int calc_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// Ports: clk, rst (async active-low), clear (sync restart), tick.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int DIV = calc_div(CLK_FREQ_HZ, BAUD_9600, OVERSAMPLE_16)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // clear realigns the phase, so no tick leaks out that cycle
  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 (8E1 with UART_RX_PARITY_EN).
// Ports: clk, rst (async active-low), rx -> rx_data, rx_valid,
//        frame_err, parity_err, busy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_HZ,
  parameter int BAUD       = BAUD_9600,
  parameter int OVERSAMPLE = OVERSAMPLE_16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t state, state_n;
  logic sync1, rx_s, rx_q;
  logic tick, start_det;
  logic [SW-1:0] scnt, scnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic perr, perr_n, pout_n;
`endif

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(start_det),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_q      <= 1'b1;
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      rx_q      <= rx_s;
      state     <= state_n;
      scnt      <= scnt_n;
      bcnt      <= bcnt_n;
      sh        <= sh_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr       <= perr_n;
      parity_err <= pout_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    scnt_n    = scnt;
    bcnt_n    = bcnt;
    sh_n      = sh;
    data_n    = rx_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    start_det = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n    = perr;
    pout_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        scnt_n = '0;
        bcnt_n = '0;
`ifdef UART_RX_PARITY_EN
        perr_n = 1'b0;
`endif
        if (rx_q && !rx_s) begin
          start_det = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == S_MID) begin
            scnt_n  = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_n = '0;
            sh_n   = {rx_s, sh[DATA_BITS-1:1]};
            bcnt_n = bcnt + 1'b1;
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_n  = '0;
            perr_n  = ^sh ^ rx_s;
            state_n = STOP;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            pout_n  = perr;
`endif
            if (rx_s) begin
              data_n  = sh;
              valid_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at a fast baud
// (DIV=4, 64-cycle bit) so full frames stay cheap.
module tb_uart_rx;

  localparam int CLK_F = 100_000_000;
  localparam int BAUD  = 1_562_500;
  localparam int OS    = 16;
  localparam int BIT   = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         checks = 0;
  int         fails = 0;
  longint     cyc = 0;
  longint     t_prev = 0;
  longint     t_last = 0;

  uart_rx #(
    .CLK_FREQ  (CLK_F),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: pops one expectation per output pulse
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || frame_err) begin
      if (rx_valid && frame_err) begin
        checks++;
        fails++;
        $display("FAIL pulse_excl: valid and frame_err both high");
      end
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%0h",
                 rx_valid, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_ferr", frame_err, e.ferr);
        check("pulse_kind_valid", rx_valid, !e.ferr);
        if (!e.ferr) begin
          check("rx_data", rx_data, e.data);
          model_data = e.data;
          t_prev = t_last;
          t_last = cyc;
        end else begin
          check("rx_data_kept", rx_data, model_data);
        end
        check("parity_err", parity_err, e.perr);
      end
    end else if (parity_err) begin
      checks++;
      fails++;
      $display("FAIL stray_parity_err: got 1 expected 0");
    end
  end

  task automatic hold(input bit b, input int cycles);
    rx = b;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input bit pb);
    exp_t e;
    e.ferr = !stop;
    e.data = d;
    e.perr = PAR_EN ? (^d ^ pb) : 1'b0;
    exp_q.push_back(e);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    if (PAR_EN) hold(pb, BIT);
    hold(stop, BIT);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 * BIT && exp_q.size() != 0; i++)
      @(posedge clk);
    @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    bit stop, pb, prev_bad;
    int gap;

    // reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ferr", frame_err, 0);
    check("post_rst_perr", parity_err, 0);

    // 1: single 0xA5, busy a few cycles after start edge
    @(posedge clk);
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_after_start", busy, 1);
      end
    join
    hold(1'b1, BIT);
    drain("drain_a5");
    check("busy_idle_a5", busy, 0);

    // 2: glitch shorter than half a bit
    hold(1'b0, BIT / 2 - 8);
    hold(1'b1, 2 * BIT);
    @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_no_pulse", exp_q.size(), 0);

    // 3: bad stop bit, then line held low
    send_frame(8'h3C, 1'b0, ^8'h3C);
    hold(1'b0, 5 * BIT);
    @(negedge clk);
    check("low_hold_busy", busy, 0);
    check("low_hold_data", rx_data, 8'hA5);
    hold(1'b1, 2 * BIT);
    drain("drain_ferr");

    // 4: back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, BIT);
    drain("drain_b2b");
    check("b2b_interval_ok",
          (t_last - t_prev >= FRAME_BITS * BIT - 2) &&
          (t_last - t_prev <= FRAME_BITS * BIT + 2), 1);

    // 5: reset during data bit 4, then 0x81
    d = 8'h5A;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(d[i], BIT);
    hold(d[4], BIT / 2);
    rst = 1'b0;
    rx = 1'b1;
    model_data = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_data", rx_data, 0);
    rst = 1'b1;
    hold(1'b1, 2 * BIT);
    @(negedge clk);
    check("after_midrst_busy", busy, 0);
    send_frame(8'h81, 1'b1, ^8'h81);
    hold(1'b1, BIT);
    drain("drain_81");

`ifdef UART_RX_PARITY_EN
    // 6: wrong then right even parity
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, BIT);
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, BIT);
    drain("drain_parity");
`endif

    // random frames
    prev_bad = 1'b0;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pb = ($urandom_range(0, 3) == 0) ? !(^d) : ^d;
      gap = $urandom_range(0, 2);
      if (prev_bad && gap == 0) gap = 1;
      if (gap != 0) hold(1'b1, gap * BIT);
      send_frame(d, stop, pb);
      prev_bad = !stop;
    end
    hold(1'b1, 2 * BIT);
    drain("drain_random");
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the transmit path.
- Recovers 8N1 frames from the serial line `rx` using a 16x oversampled tick derived from the 100 MHz system clock.
- Presents each received byte on a parallel bus with a one-cycle valid strobe; flags framing errors.
- Sits between the board RX pin and the user logic.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; asynchronous to clk; idles high.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is valid in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; tick counter, sample counter and bit counter clear to 0.
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0.
  - Both synchronizer flops are set to 1 (line idle).
- Synchronizer:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - The FSM sees line edges 2 cycles late; this latency is accepted.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division; 651 at the defaults.
  - Counter runs 0..DIV-1; tick pulses for one cycle when the counter equals DIV-1, then the counter wraps to 0.
  - On start detection the counter is forced to 0 so sampling phase aligns to the start edge.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - Detects a falling edge of rx_s (previous 1, current 0) and moves to START.
  - Sample counter clears.
  - A line held continuously low never triggers a start.
- START:
  - On the tick with sample count == OVERSAMPLE/2-1, i.e. bit centre, samples rx_s.
  - rx_s=1: false start (glitch); return to IDLE with no output.
  - rx_s=0: clear the sample counter and go to DATA.
- DATA:
  - Every OVERSAMPLE ticks, at bit centre, shift rx_s into a shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if enabled, otherwise STOP.
- STOP:
  - At bit centre, sample rx_s.
  - rx_s=1: load rx_data from the shift register and pulse rx_valid on the following cycle.
  - rx_s=0: pulse frame_err; rx_data is left unchanged and rx_valid is not asserted.
  - Either way, return to IDLE in the same cycle as the pulse.
- Throughput:
  - Re-arming at mid-stop allows back-to-back frames with no idle gap.
  - Total frame latency: start edge to rx_valid is about 9.5 bit periods + 3 cycles.
- Simultaneous events: a falling edge during STOP before mid-bit is ignored; only IDLE detects starts.
- rx_valid and frame_err are mutually exclusive and never both high.
- Reset asserted mid-frame aborts the frame with no pulse. After release, the block waits for the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state samples one even-parity bit after the data bits.
  - If the XOR of the data bits and the parity bit is 1, parity_err pulses together with the STOP-state outcome.
  - rx_data still loads if the stop bit is good; the consumer decides whether to discard.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_err is driven constant 0.

Decomposition:
- Package uart_pkg:
  - FSM state enum.
  - Default constants CLK_FREQ_HZ and BAUD_9600.
  - OVERSAMPLE_16.
  - Function computing DIV.
  - The transmit path reuses the same package.
- Sub-module uart_rx_tick:
  - Oversample tick generator with a sync-clear input.
  - Counter width is $clog2(DIV).

Test Plan:
1. Send 0xA5 as 8N1 at 9600 baud, bit period 10417 cycles -> exactly one rx_valid pulse with rx_data=0xA5; frame_err=0; busy high from about 3 cycles after the start edge until the pulse.
2. Drive rx low for 4000 cycles, shorter than half a bit, then high -> FSM returns to IDLE; no rx_valid or frame_err; busy deasserts.
3. Send 0x3C with the stop bit driven low -> one frame_err pulse; rx_valid stays 0; rx_data keeps its previous value. Then hold rx low for 5 bit periods -> no further pulses.
4. Send 0x00 then 0xFF back-to-back with zero idle gap -> two rx_valid pulses carrying 0x00 then 0xFF, roughly 104170 cycles apart.
5. Assert rst low during data bit 4 of a frame, release it, then send 0x81 -> no pulse from the aborted frame; the next frame gives rx_data=0x81.
6. With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong; even parity requires 1) -> rx_valid with rx_data=0x07 plus parity_err; repeat with parity bit 1 -> parity_err stays 0.
